// File: rtl/mux_4x_scan_ctrl.sv
// mux_4x_scan_ctrl: round-robin scan controller for a shared 4:1 N-bit mux
// and seven-segment display bus. All outputs are registered.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset
//   en       - scan enable (0 returns to IDLE)
//   mask     - per-channel enable, bit i enables channel i
//   a,b,c,d  - channel 0..3 data, N bits
//   sel      - current channel index
//   y        - data of the selected channel, aligned with sel
//   dig_en_n - active-low one-hot digit enable
//   tick     - high in the first cycle of each new slot
//
// Optional macro SCAN_BLANK_EN: blanks dig_en_n during the first cycle of
// every slot (requires DIV >= 2).
module mux_4x_scan_ctrl #(
  parameter  int N     = 8,
  parameter  int DIV   = 4,
  localparam int DIV_W = $clog2(DIV) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [3:0]   mask,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  input  logic [N-1:0] d,
  output logic [1:0]   sel,
  output logic [N-1:0] y,
  output logic [3:0]   dig_en_n,
  output logic         tick
);

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
  if (DIV < 2) begin : g_div_chk
    $error("SCAN_BLANK_EN needs DIV >= 2");
  end
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [1:0]       sel_q, sel_d;
  logic [N-1:0]     y_q, y_d;
  logic [3:0]       dig_q, dig_d;
  logic             tick_q, tick_d;
  logic [1:0]       nxt;

  // First enabled index among cur+1, cur+2, cur+3, cur (mod 4).
  // From cur=3 this is also the lowest set mask bit.
  function automatic logic [1:0] next_idx(
    input logic [1:0] cur,
    input logic [3:0] m
  );
    logic [1:0] idx;
    next_idx = cur;
    for (int k = 3; k >= 1; k--) begin
      idx = cur + 2'(k);
      if (m[idx]) next_idx = idx;
    end
  endfunction

  function automatic logic [N-1:0] pick(input logic [1:0] s);
    logic [N-1:0] v;
    unique case (s)
      2'd0:    v = a;
      2'd1:    v = b;
      2'd2:    v = c;
      default: v = d;
    endcase
    return v;
  endfunction

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sel_d   = sel_q;
    y_d     = '0;
    dig_d   = 4'b1111;
    tick_d  = 1'b0;
    nxt     = '0;
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (en && (mask != 4'b0000)) begin
          state_d = SCAN;
          sel_d   = next_idx(2'd3, mask);
          tick_d  = 1'b1;
        end
      end
      default: begin
        if (!en || (mask == 4'b0000)) begin
          state_d = IDLE;
          presc_d = '0;
        end else begin
          nxt = next_idx(sel_q, mask);
          // A masked current channel abandons its slot at once.
          if (!mask[sel_q] ||
              presc_q == DIV_W'(DIV - 1)) begin
            sel_d   = nxt;
            presc_d = '0;
            tick_d  = 1'b1;
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
      end
    endcase
    if (state_d == SCAN) begin
      y_d = pick(sel_d);
      if (!(BLANK && presc_d == '0))
        dig_d = ~(4'b0001 << sel_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      sel_q   <= 2'b00;
      y_q     <= '0;
      dig_q   <= 4'b1111;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      dig_q   <= dig_d;
      tick_q  <= tick_d;
    end
  end

  assign sel      = sel_q;
  assign y        = y_q;
  assign dig_en_n = dig_q;
  assign tick     = tick_q;

endmodule
